sap_cpu_core: RTL and testbench
===============================

# sap_cpu_core

Parametrised SAP-class accumulator CPU core: the next-generation replacement for the fixed 8-bit CPU top, with configurable data width and memory depth. The internal bus is a registered multiplexer with no tri-states. The core adds a program-loader handshake, conditional jumps on carry/zero, immediate load, store and halt. It sits directly under the Tiny Tapeout wrapper, which maps the loader, run and output ports onto `ui_in`/`uio_*`/`uo_out`.

## Interface
- `DATA_W`, 8: data and instruction word width. Must be ≥ 8.
- `ADDR_W`, 4: RAM address width (depth 2^ADDR_W). Must satisfy ADDR_W ≤ DATA_W−4.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `prog_valid` in 1: loader write request.
- `prog_ready` out 1: core accepts loader writes (high only in IDLE).
- `prog_addr` in ADDR_W: loader write address.
- `prog_data` in DATA_W: loader write data.
- `run` in 1: level; start execution from IDLE, return to IDLE from HALT when low.
- `out_data` out DATA_W: output register.
- `out_valid` out 1: output register holds a new value.
- `out_ready` in 1: output consumer ready. Used only with SAP_CPU_OUT_HS_EN.
- `halted` out 1: core is in HALT.
- `cf`, `zf` out 1 each: carry and zero flags.
- `pc_dbg` out ADDR_W: current PC.

## Operation
- Instruction format: opcode = `[DATA_W-1:DATA_W-4]`; operand = `[ADDR_W-1:0]`; immediate = `[DATA_W-5:0]`, zero-extended.
- RAM is a flop array. Reads are combinational from MAR; writes occur on the clock edge.
- States: IDLE, F0, F1, X2, X3, X4, OUTW, HALT.
- IDLE:
  - `prog_valid` high writes RAM[`prog_addr`] ← `prog_data`. This takes priority over `run`.
  - `run` high with `prog_valid` low: PC, A, B and flags clear, then go to F0.
- F0: MAR ← PC.
- F1: IR ← RAM[MAR]; PC ← PC+1, modulo 2^ADDR_W so the last address wraps to 0.
- Opcodes. All actions in X2 unless noted; next state is F0 after the last listed step.
  - 0x0 NOP: X2 only.
  - 0x1 LDA: X2 MAR ← operand; X3 A ← RAM.
  - 0x2 ADD / 0x3 SUB: X2 MAR ← operand; X3 B ← RAM; X4 A ← A±B, flags updated.
  - 0x4 STA: X2 MAR ← operand; X3 RAM[MAR] ← A.
  - 0x5 LDI: A ← immediate.
  - 0x6 JMP: PC ← operand.
  - 0x7 JC: PC ← operand if `cf`.
  - 0x8 JZ: PC ← operand if `zf`.
  - 0xE OUT: `out_data` ← A; `out_valid` set.
  - 0xF HLT: go to HALT.
  - All other opcodes execute as NOP.
- Arithmetic is DATA_W-bit modular.
  - ADD: `cf` = carry out.
  - SUB: computed as A + ~B + 1; `cf` = carry out, so 1 means no borrow (A ≥ B).
  - `zf` = (result == 0).
  - Only ADD and SUB change flags.
- HALT: `halted` = 1; the core waits for `run` low, then goes to IDLE. RAM, A and `out_data` are retained.

## Timing
- Instruction cycle counts, including the 2-cycle fetch:
  - NOP, LDI, JMP, JC, JZ, OUT, HLT: 3 cycles.
  - LDA, STA: 4 cycles.
  - ADD, SUB: 5 cycles.
- `out_valid` rises on the X2 edge of OUT.
- Reset (asynchronous, effective mid-instruction as well):
  - State goes to IDLE.
  - PC, MAR, IR, A, B, `out_data`, `cf`, `zf`, `out_valid`, `halted` and all RAM words go to 0.
  - `prog_ready` goes to 1.
- A loader write and a start in the same cycle: the write occurs and the core stays in IDLE.
- `prog_valid` outside IDLE is ignored; `prog_ready` is 0.
- `run` dropping during execution has no effect until HALT.

## Configuration
- `SAP_CPU_OUT_HS_EN` defined:
  - OUT moves from X2 to OUTW and holds `out_valid` until a cycle with `out_ready` high.
  - It then clears `out_valid` and goes to F0.
  - OUT takes 3 + stall cycles.
- `SAP_CPU_OUT_HS_EN` undefined:
  - `out_valid` is a 1-cycle pulse; `out_ready` is ignored; OUTW is unreachable.

## Structure
- Package `sap_pkg`: opcode localparams, state enum, instruction-field index helpers.
- One sub-module `sap_alu` (combinational): DATA_W add/sub producing result, carry and zero.

## Test plan
All programs use DATA_W=8, ADDR_W=4 and are loaded through the prog handshake.
- Add: program 0:0x1E, 1:0x2F, 2:0xE0, 3:0xF0; RAM[14]=0x05, RAM[15]=0x07; `run`=1 → `out_data`=0x0C, `out_valid` high 12 cycles after start, then `halted`=1, `cf`=0, `zf`=0.
- Subtract to zero and branch: LDI 3; SUB [15]=0x03; JZ 6; OUT; HLT → `zf`=1, `cf`=1, jump taken, OUT skipped, `halted` with `out_valid` never high.
- Overflow and store: LDI 0xF; ADD [15]=0xF1 → A=0x00, `cf`=1, `zf`=1; STA 13 → RAM[13]=0x00, verified by a subsequent LDA 13; OUT = 0x00.
- PC wrap: NOPs in all 16 words → `pc_dbg` wraps from 15 to 0; `halted` stays 0.
- Reset mid-ADD: assert `rst_n`=0 in X3 → all outputs 0, `prog_ready`=1 immediately; a write issued the same cycle as `run` is stored and the core stays in IDLE.
- With SAP_CPU_OUT_HS_EN: `out_ready` held low for 5 cycles → `out_valid` and `out_data` held steady and PC frozen; completion occurs on the first cycle with `out_ready` high.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP accumulator core: opcodes, FSM states and
// instruction-field index helpers.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        F0   = 3'd1,
        F1   = 3'd2,
        X2   = 3'd3,
        X3   = 3'd4,
        X4   = 3'd5,
        OUTW = 3'd6,
        HALT = 3'd7
    } state_t;

    // Opcode occupies the top nibble; the immediate is everything below it.
    function automatic int op_lsb(input int dw);
        return dw - 4;
    endfunction

    function automatic int imm_msb(input int dw);
        return dw - 5;
    endfunction

endpackage

// File: rtl/sap_alu.sv
// Combinational DATA_W adder/subtractor; subtraction is A + ~B + 1 so the
// carry out reads as "no borrow".
module sap_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b ^ {DATA_W{sub}}} + {{DATA_W{1'b0}}, sub};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        zero   = (sum[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/sap_cpu_core.sv
// Parametrised SAP-class accumulator CPU with program-loader handshake.
// Define SAP_CPU_OUT_HS_EN to make OUT stall in OUTW until out_ready.
module sap_cpu_core
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              run,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic              cf,
    output logic              zf,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int OP_LSB  = op_lsb(DATA_W);
    localparam int IMM_MSB = imm_msb(DATA_W);

    state_t            state;
    logic [ADDR_W-1:0] pc, mar;
    logic [DATA_W-1:0] ir, a, b;
    logic [DATA_W-1:0] ram [DEPTH];

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu_y;
    logic              alu_c, alu_z;

    assign opcode     = ir[DATA_W-1:OP_LSB];
    assign operand    = ir[ADDR_W-1:0];
    assign imm        = DATA_W'(ir[IMM_MSB:0]);
    assign rd         = ram[mar];
    assign prog_ready = (state == IDLE);
    assign halted     = (state == HALT);
    assign pc_dbg     = pc;

    sap_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a),
        .b      (b),
        .sub    (opcode == OP_SUB),
        .result (alu_y),
        .carry  (alu_c),
        .zero   (alu_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            cf        <= 1'b0;
            zf        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else begin
`ifndef SAP_CPU_OUT_HS_EN
            out_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Loader write wins over run so a same-cycle start is dropped.
                    if (prog_valid) begin
                        ram[prog_addr] <= prog_data;
                    end else if (run) begin
                        pc    <= '0;
                        a     <= '0;
                        b     <= '0;
                        cf    <= 1'b0;
                        zf    <= 1'b0;
                        state <= F0;
                    end
                end
                F0: begin
                    mar   <= pc;
                    state <= F1;
                end
                F1: begin
                    ir    <= rd;
                    pc    <= pc + ADDR_W'(1);
                    state <= X2;
                end
                X2: begin
                    state <= F0;
                    case (opcode)
                        OP_NOP: ;
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            mar   <= operand;
                            state <= X3;
                        end
                        OP_LDI: a <= imm;
                        OP_JMP: pc <= operand;
                        OP_JC:  if (cf) pc <= operand;
                        OP_JZ:  if (zf) pc <= operand;
                        OP_OUT: begin
                            out_data  <= a;
                            out_valid <= 1'b1;
`ifdef SAP_CPU_OUT_HS_EN
                            state     <= OUTW;
`endif
                        end
                        OP_HLT: state <= HALT;
                        default: ;
                    endcase
                end
                X3: begin
                    state <= F0;
                    case (opcode)
                        OP_LDA: a <= rd;
                        OP_ADD, OP_SUB: begin
                            b     <= rd;
                            state <= X4;
                        end
                        OP_STA: ram[mar] <= a;
                        default: ;
                    endcase
                end
                X4: begin
                    a     <= alu_y;
                    cf    <= alu_c;
                    zf    <= alu_z;
                    state <= F0;
                end
                OUTW: begin
`ifdef SAP_CPU_OUT_HS_EN
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= F0;
                    end
`else
                    // Unreachable without the handshake; kept benign.
                    out_valid <= out_valid & ~out_ready;
                    state     <= F0;
`endif
                end
                HALT: begin
                    if (!run) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_cpu_core.sv
// Self-checking bench for sap_cpu_core: loads programs through the loader
// port and scoreboards every OUT value against expected results.
module tb_sap_cpu_core;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              prog_valid;
    logic              prog_ready;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              run;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              halted;
    logic              cf, zf;
    logic [ADDR_W-1:0] pc_dbg;

    int n_chk  = 0;
    int n_fail = 0;
    int n_out  = 0;
    logic [DATA_W-1:0] sb[$];

    sap_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .run        (run),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .halted     (halted),
        .cf         (cf),
        .zf         (zf),
        .pc_dbg     (pc_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: an accepted OUT pops the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) chk("sb_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            else chk("sb_out_data", 32'(out_data), 32'(sb.pop_front()));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        prog_valid = 1'b1;
        prog_addr  = addr;
        prog_data  = data;
        tick();
        prog_valid = 1'b0;
    endtask

    task automatic do_reset();
        run    = 1'b0;
        rst_n  = 1'b0;
        #2;
        rst_n  = 1'b1;
        tick();
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        if (!halted) chk("halt_timeout", 32'(n), 32'(budget + 1));
    endtask

    task automatic stop_run();
        run = 1'b0;
        tick(2);
        chk("back_to_idle", 32'(prog_ready), 32'd1);
    endtask

    initial begin
        int cycles;
        int outs0;
        logic wrap;
        logic [ADDR_W-1:0] prev_pc;

        rst_n      = 1'b0;
        prog_valid = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        run        = 1'b0;
        out_ready  = 1'b1;
        tick(2);
        chk("rst_prog_ready", 32'(prog_ready), 32'd1);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_pc", 32'(pc_dbg), 32'd0);
        chk("rst_flags", 32'({cf, zf}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Add 5+7, OUT, HLT; a loader write during execution must be ignored.
        wr(0, 8'h1E); wr(1, 8'h2F); wr(2, 8'hE0); wr(3, 8'hF0);
        wr(14, 8'h05); wr(15, 8'h07);
        sb.push_back(8'h0C);
        run = 1'b1;
        tick();
        prog_valid = 1'b1; prog_addr = 4'd15; prog_data = 8'h55;
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
            if (cycles == 1) chk("busy_prog_ready", 32'(prog_ready), 32'd0);
            if (cycles == 3) prog_valid = 1'b0;
        end
        chk("add_out_latency", 32'(cycles), 32'd12);
        wait_halt(20);
        chk("add_halted", 32'(halted), 32'd1);
        chk("add_cf", 32'(cf), 32'd0);
        chk("add_zf", 32'(zf), 32'd0);
        chk("add_out_hold", 32'(out_data), 32'h0C);
        stop_run();

        // Subtract to zero, JZ skips the OUT.
        do_reset();
        wr(0, 8'h53); wr(1, 8'h3F); wr(2, 8'h86); wr(3, 8'hE0);
        wr(4, 8'hF0); wr(6, 8'hF0); wr(15, 8'h03);
        outs0 = n_out;
        run = 1'b1;
        tick();
        wait_halt(40);
        chk("sub_zf", 32'(zf), 32'd1);
        chk("sub_cf", 32'(cf), 32'd1);
        chk("jz_taken_pc", 32'(pc_dbg), 32'd7);
        chk("jz_no_out", 32'(n_out), 32'(outs0));
        stop_run();

        // Overflow to zero, store, reload and output.
        do_reset();
        wr(0, 8'h5F); wr(1, 8'h2F); wr(2, 8'h4D); wr(3, 8'h55);
        wr(4, 8'h1D); wr(5, 8'hE0); wr(6, 8'hF0);
        wr(13, 8'hAA); wr(15, 8'hF1);
        sb.push_back(8'h00);
        run = 1'b1;
        tick();
        wait_halt(60);
        chk("ovf_cf", 32'(cf), 32'd1);
        chk("ovf_zf", 32'(zf), 32'd1);
        chk("sta_lda_out", 32'(out_data), 32'h00);
        stop_run();

        // All-NOP memory: PC wraps 15 -> 0 and never halts.
        do_reset();
        run = 1'b1;
        tick();
        wrap = 1'b0;
        prev_pc = pc_dbg;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (prev_pc == 4'd15 && pc_dbg == 4'd0) wrap = 1'b1;
            prev_pc = pc_dbg;
        end
        chk("pc_wrap", 32'(wrap), 32'd1);
        chk("nop_not_halted", 32'(halted), 32'd0);
        do_reset();

        // Reset asserted in the X3 cycle of an ADD.
        wr(0, 8'h59); wr(1, 8'hE0); wr(2, 8'h2F); wr(15, 8'h01);
        sb.push_back(8'h09);
        run = 1'b1;
        tick();
        tick(9);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_prog_ready", 32'(prog_ready), 32'd1);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_pc", 32'(pc_dbg), 32'd0);
        chk("mid_rst_misc", 32'({out_valid, halted, cf, zf}), 32'd0);
        run = 1'b0;
        rst_n = 1'b1;
        tick();
        // Same-cycle write and run: write lands, core stays idle.
        prog_valid = 1'b1; prog_addr = 4'd0; prog_data = 8'h1F; run = 1'b1;
        tick();
        prog_valid = 1'b0; run = 1'b0;
        chk("wr_run_idle", 32'(prog_ready), 32'd1);
        chk("wr_run_pc", 32'(pc_dbg), 32'd0);
        wr(1, 8'hE0); wr(2, 8'h57); wr(3, 8'hE0); wr(4, 8'hF0);
        sb.push_back(8'h00);   // RAM[15] cleared by reset
        sb.push_back(8'h07);
        run = 1'b1;
        tick();
        wait_halt(60);
        stop_run();

`ifdef SAP_CPU_OUT_HS_EN
        // Output stall: valid, data and PC hold while out_ready is low.
        do_reset();
        out_ready = 1'b0;
        wr(0, 8'h56); wr(1, 8'hE0); wr(2, 8'hF0);
        sb.push_back(8'h06);
        run = 1'b1;
        tick();
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        chk("hs_valid_seen", 32'(out_valid), 32'd1);
        prev_pc = pc_dbg;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hs_hold_valid", 32'(out_valid), 32'd1);
            chk("hs_hold_data", 32'(out_data), 32'h06);
            chk("hs_hold_pc", 32'(pc_dbg), 32'(prev_pc));
        end
        out_ready = 1'b1;
        tick();
        chk("hs_valid_clear", 32'(out_valid), 32'd0);
        wait_halt(20);
        stop_run();
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
